// File: rtl/ifetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : ifetch_unit
// Description : Instruction fetch stage. Holds the PC and issues one word
//               fetch at a time over a req/gnt/rvalid handshake. Returned
//               words and their PC go into a small prefetch FIFO that feeds
//               decode over valid/ready. A redirect flushes the FIFO and
//               discards any in-flight response.
//               Optional macro IFETCH_PERF_CNT_EN adds the perf_fetch_cnt
//               and perf_flush_cnt counter outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module ifetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2               // 2 or 4
) (
    input  logic        clk,
    input  logic        rstn,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready
`ifdef IFETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_flush_cnt
`endif
);

    localparam int             PW      = $clog2(FIFO_DEPTH);
    localparam int             CW      = PW + 1;
    localparam logic [CW-1:0]  DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0]  ONE_C   = CW'(1);
    localparam logic [PW-1:0]  PINC_C  = PW'(1);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [31:0]    pc_q, pc_d;
    logic [31:0]    data_q [FIFO_DEPTH];
    logic [31:0]    epc_q  [FIFO_DEPTH];
    logic [PW-1:0]  rd_ptr_q, wr_ptr_q;
    logic [CW-1:0]  count_q;
    logic           fifo_full;
    logic           push;
    logic           pop;

    assign fifo_full   = (count_q == DEPTH_C);
    assign instr_valid = (count_q != '0);
    assign instr       = data_q[rd_ptr_q];
    assign instr_pc    = epc_q[rd_ptr_q];
    assign imem_addr   = pc_q;
    // A response arriving with a redirect is stale; a head popped with a
    // redirect is squashed along with the rest of the FIFO.
    assign push        = (state_q == S_WAIT) && imem_rvalid && !redirect;
    assign pop         = instr_valid && instr_ready && !redirect;

    // Next-state, PC update and request generation; redirect overrides all.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        imem_req = 1'b0;
        if (redirect) begin
            pc_d = {redirect_pc[31:2], 2'b00};
            case (state_q)
                S_REQ:   state_d = imem_gnt    ? S_DROP : S_REQ;
                S_WAIT:  state_d = imem_rvalid ? S_REQ  : S_DROP;
                // The outstanding response is consumed if it lands now.
                S_DROP:  state_d = imem_rvalid ? S_REQ  : S_DROP;
                default: state_d = S_REQ;
            endcase
        end else begin
            case (state_q)
                S_REQ: begin
                    // Held low while in reset so nothing is issued early.
                    imem_req = rstn && !fifo_full;
                    if (imem_req && imem_gnt) begin
                        state_d = S_WAIT;
                        pc_d    = pc_q + 32'd4;
                    end
                end
                S_WAIT, S_DROP: begin
                    if (imem_rvalid) begin
                        state_d = S_REQ;
                    end
                end
                default: state_d = S_REQ;
            endcase
        end
    end

    // State and PC registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_REQ;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    // Prefetch FIFO: circular buffer, flushed on redirect. The PC stored
    // with a word is pc-4 because pc advanced when the request was granted.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                data_q[i] <= '0;
                epc_q[i]  <= '0;
            end
        end else if (redirect) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                data_q[wr_ptr_q] <= imem_rdata;
                epc_q[wr_ptr_q]  <= pc_q - 32'd4;
                wr_ptr_q         <= wr_ptr_q + PINC_C;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PINC_C;
            end
            if (push && !pop) begin
                count_q <= count_q + ONE_C;
            end else if (pop && !push) begin
                count_q <= count_q - ONE_C;
            end
        end
    end

`ifdef IFETCH_PERF_CNT_EN
    // Counts decoded instructions and redirect pulses; both wrap.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            perf_fetch_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (pop) begin
                perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            end
            if (redirect) begin
                perf_flush_cnt <= perf_flush_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_ifetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_ifetch_unit
// Description : Self-checking bench for ifetch_unit. A memory responder and
//               an occupancy/PC-stream reference model run inside one tick
//               task; directed steps cover the key scenarios, followed by a
//               randomized run.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ifetch_unit;

    localparam int DEPTH = 2;

    logic        clk;
    logic        rstn;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;
`ifdef IFETCH_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_flush_cnt;
`endif

    ifetch_unit #(
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk            (clk),
        .rstn           (rstn),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_ready    (instr_ready)
`ifdef IFETCH_PERF_CNT_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_flush_cnt (perf_flush_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int          n_cmp = 0;
    int          n_err = 0;

    // Reference model state
    bit          pend;          // a granted request awaits its response
    bit          stale;         // that response must be discarded
    int          pend_wait;     // cycles before rvalid
    logic [31:0] pend_addr;
    int          occ;           // expected FIFO occupancy
    logic [31:0] exp_fetch;     // next address expected on the bus
    logic [31:0] exp_pc;        // next PC expected at decode
    int          m_fetch, m_flush;
    int          lat_min, lat_max, gnt_pct;
    logic [31:0] flog[$];

    // Values seen in the most recent tick
    bit          last_req, last_valid, last_fire;
    logic [31:0] last_addr, last_fire_addr;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        pend = 0; stale = 0; pend_wait = 0; pend_addr = '0;
        occ = 0; exp_fetch = 32'h0; exp_pc = 32'h0;
        m_fetch = 0; m_flush = 0;
        flog.delete();
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        redirect = 1'b0; redirect_pc = '0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        repeat (3) @(negedge clk);
        model_reset();
        rstn = 1'b1;
    endtask

    // One clock cycle: drive inputs at the falling edge, check the DUT
    // against the model, then advance the model across the rising edge.
    task automatic tick(input bit rd, input logic [31:0] rpc);
        bit          exp_req, pop, fire, rv;
        redirect    = rd;
        redirect_pc = rpc;
        rv          = pend && (pend_wait == 0);
        imem_rvalid = rv;
        imem_rdata  = rv ? memf(pend_addr) : $urandom;
        #1;
        imem_gnt = imem_req && ($urandom_range(99) < gnt_pct);
        #1;
        exp_req = !pend && (occ < DEPTH) && !rd;
        chk("imem_req", imem_req, exp_req);
        if (exp_req) chk("imem_addr", imem_addr, exp_fetch);
        chk("instr_valid", instr_valid, occ > 0);
        pop = instr_valid && instr_ready && !rd;
        if (pop) begin
            chk("instr_pc", instr_pc, exp_pc);
            chk("instr", instr, memf(exp_pc));
        end
        fire           = imem_req && imem_gnt;
        last_req       = imem_req;
        last_addr      = imem_addr;
        last_valid     = instr_valid;
        last_fire      = fire;
        last_fire_addr = imem_addr;
        @(posedge clk);
        if (pop) begin occ--; exp_pc += 32'd4; m_fetch++; end
        if (rv) begin
            if (!rd && !stale) occ++;
            pend = 0; stale = 0;
        end else if (pend) begin
            pend_wait--;
        end
        if (rd) begin
            occ = 0;
            exp_fetch = {rpc[31:2], 2'b00};
            exp_pc    = {rpc[31:2], 2'b00};
            m_flush++;
            if (pend) stale = 1;
        end
        if (fire) begin
            pend      = 1;
            stale     = 0;
            pend_addr = last_fire_addr;
            pend_wait = int'($urandom_range(lat_max, lat_min)) - 1;
            exp_fetch += 32'd4;
            flog.push_back(last_fire_addr);
        end
        @(negedge clk);
        redirect = 1'b0;
    endtask

    task automatic wait_fire(input string tag);
        int k;
        k = 0;
        do begin tick(0, '0); k++; end while (!last_fire && k < 40);
        chk({tag, "_timeout"}, last_fire, 1'b1);
    endtask

    initial begin
        int k;
        lat_min = 1; lat_max = 1; gnt_pct = 100;
        instr_ready = 1'b1;

        // Reset values while reset is held
        do_reset();
        rstn = 1'b0;
        #2;
        chk("rst_req", imem_req, 1'b0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_valid", instr_valid, 1'b0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_pc", instr_pc, 32'h0);
        @(negedge clk);
        rstn = 1'b1;

        // Streaming with immediate grant and 1-cycle memory
        repeat (10) tick(0, '0);
        chk("seq_len", flog.size() >= 3, 1'b1);
        if (flog.size() >= 3) begin
            chk("seq0", flog[0], 32'h0);
            chk("seq1", flog[1], 32'h4);
            chk("seq2", flog[2], 32'h8);
        end

        // Decode stalled: FIFO fills to DEPTH and fetching stops
        do_reset();
        instr_ready = 1'b0;
        repeat (8) tick(0, '0);
        #1;
        chk("full_req", imem_req, 1'b0);
        chk("full_valid", instr_valid, 1'b1);
        chk("full_head_pc", instr_pc, 32'h0);
        chk("full_head", instr, memf(32'h0));
        instr_ready = 1'b1;
        wait_fire("resume");
        chk("resume_addr", last_fire_addr, 32'h8);

        // Redirect while waiting on a slow response
        lat_min = 4; lat_max = 4;
        wait_fire("slow");
        lat_min = 1; lat_max = 1;
        tick(1, 32'h0000_0103);
        wait_fire("redir");
        chk("redir_addr", last_fire_addr, 32'h100);

        // Redirect coinciding with rvalid
        lat_min = 2; lat_max = 2;
        k = 0;
        while (!(pend && pend_wait == 0) && k < 40) begin tick(0, '0); k++; end
        chk("rv_sync_timeout", k < 40, 1'b1);
        lat_min = 1; lat_max = 1;
        tick(1, 32'h0000_0200);
        tick(0, '0);
        chk("rv_redir_req", last_req, 1'b1);
        chk("rv_redir_addr", last_addr, 32'h200);

        // Redirect with a full FIFO and decode ready
        instr_ready = 1'b0;
        k = 0;
        while (occ < DEPTH && k < 40) begin tick(0, '0); k++; end
        chk("fill_timeout", k < 40, 1'b1);
        instr_ready = 1'b1;
        tick(1, 32'h0000_0300);
        tick(0, '0);
        chk("flush_valid", last_valid, 1'b0);
`ifdef IFETCH_PERF_CNT_EN
        chk("perf_fetch_a", perf_fetch_cnt, 32'(m_fetch));
        chk("perf_flush_a", perf_flush_cnt, 32'(m_flush));
`endif

        // PC wrap at the top of the address space
        tick(1, 32'hFFFF_FFFC);
        wait_fire("wrap_a");
        chk("wrap_addr_a", last_fire_addr, 32'hFFFF_FFFC);
        wait_fire("wrap_b");
        chk("wrap_addr_b", last_fire_addr, 32'h0000_0000);

        // Randomized traffic
        gnt_pct = 70; lat_min = 1; lat_max = 3;
        for (int i = 0; i < 500; i++) begin
            instr_ready = ($urandom_range(99) < 70);
            if ($urandom_range(99) < 4) tick(1, $urandom);
            else                        tick(0, '0);
        end
`ifdef IFETCH_PERF_CNT_EN
        chk("perf_fetch_b", perf_fetch_cnt, 32'(m_fetch));
        chk("perf_flush_b", perf_flush_cnt, 32'(m_flush));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
